// File: rtl/branch_redirect_unit.sv
// Resolves the registered conditional branch against the ALU zero flag, redirects the PC
// and squashes the wrong-path instructions. Optional statistics counters under BRANCH_STATS_EN.
module branch_redirect_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              branch_reg,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              pc_src,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              flush_id,
  output logic              busy,
  output logic [15:0]       branch_cnt,
  output logic [15:0]       taken_cnt
);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("branch_redirect_unit: FLUSH_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  // branch_reg/zero are only looked at in IDLE; in other states they belong to squashed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      redirect_pc <= '0;
    end else if (run) begin
      case (state)
        IDLE: begin
          if (branch_reg && zero) begin
            redirect_pc <= branch_target;
            state       <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (FLUSH_CYCLES == 1) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_INIT;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == 4'd1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline controls are dropped while frozen; busy keeps reporting the held state
  assign pc_src   = run && (state == REDIRECT);
  assign flush_if = run && (state == REDIRECT);
  assign flush_id = run && (state == REDIRECT || state == FLUSH);
  assign busy     = (state != IDLE);

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_q;
  logic [15:0] taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q <= '0;
      taken_q  <= '0;
    end else if (run && state == IDLE && branch_reg) begin
      if (branch_q != 16'hFFFF) branch_q <= branch_q + 16'd1;
      if (zero && taken_q != 16'hFFFF) taken_q <= taken_q + 16'd1;
    end
  end

  assign branch_cnt = branch_q;
  assign taken_cnt  = taken_q;
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
`endif

endmodule
